aes_decipher_block_param: RTL and testbench

//   Parametrised AES inverse-cipher datapath (FIPS-197 InvCipher) for AES-128 and, optionally, AES-256.

---
 rtl/aes_decipher_block_param.sv | 178 +++++++++++++++++
 tb/tb_aes_decipher_block_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decipher_block_param.sv
// Iterative AES inverse-cipher datapath (AES-128, optionally AES-256) with configurable
// InvSubBytes width. Round keys come from an external provider indexed by the round output.
module aes_decipher_block_param #(
  parameter int SBOX_LANES  = 1,
  parameter bit SUPPORT_256 = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         abort,
  input  logic         keylen,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [3:0]   round,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         done
);

  localparam int         S        = 4 / ((SBOX_LANES > 0) ? SBOX_LANES : 1);
  localparam logic [1:0] CTR_LAST = 2'(S - 1);

  if (SBOX_LANES != 1 && SBOX_LANES != 2 && SBOX_LANES != 4) begin : g_bad_lanes
    $error("aes_decipher_block_param: SBOX_LANES must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_SBOX, ST_MAIN} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse affine transform followed by the GF(2^8) inverse, computed as x^254.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] x, x2, x3, x12, x15, x240;
    x    = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
    return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = s[127 - 8*(r + 4*c) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 32] = {
        gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
        gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
        gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
        gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
    end
    return o;
  endfunction

  state_t       r_fsm;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic [1:0]   r_ctr;
  logic         r_ready;
  logic         r_done;

  logic [127:0] w_init;
  logic [127:0] w_main;
  logic [127:0] w_final;
  logic [127:0] w_sbox;

  assign w_init  = inv_shift_rows(block ^ round_key);
  assign w_main  = inv_shift_rows(inv_mix_columns(r_state ^ round_key));
  assign w_final = r_state ^ round_key;

  // Only the SBOX_LANES words selected by the counter are substituted this cycle.
  always_comb begin
    w_sbox = r_state;
    for (int l = 0; l < SBOX_LANES; l++) begin
      w_sbox[127 - 32*(int'(r_ctr)*SBOX_LANES + l) -: 32] =
        inv_sub_word(r_state[127 - 32*(int'(r_ctr)*SBOX_LANES + l) -: 32]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm   <= ST_IDLE;
      r_state <= '0;
      r_round <= '0;
      r_ctr   <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_fsm != ST_IDLE && abort) begin
        r_fsm   <= ST_IDLE;
        r_ready <= 1'b1;
      end else begin
        case (r_fsm)
          ST_IDLE: begin
            if (next && !abort) begin
              r_round <= (SUPPORT_256 && keylen) ? 4'd14 : 4'd10;
              r_ready <= 1'b0;
              r_fsm   <= ST_INIT;
            end
          end
          ST_INIT: begin
            r_state <= w_init;
            r_ctr   <= '0;
            r_fsm   <= ST_SBOX;
          end
          ST_SBOX: begin
            r_state <= w_sbox;
            if (r_ctr == CTR_LAST) begin
              r_ctr   <= '0;
              r_round <= r_round - 4'd1;
              r_fsm   <= ST_MAIN;
            end else begin
              r_ctr <= r_ctr + 2'd1;
            end
          end
          ST_MAIN: begin
            if (r_round != 4'd0) begin
              r_state <= w_main;
              r_ctr   <= '0;
              r_fsm   <= ST_SBOX;
            end else begin
              r_state <= w_final;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_fsm   <= ST_IDLE;
            end
          end
          default: r_fsm <= ST_IDLE;
        endcase
      end
    end
  end

  assign round     = r_round;
  assign new_block = r_state;
  assign ready     = r_ready;
  assign done      = r_done;

endmodule

// File: tb/tb_aes_decipher_block_param.sv
// Bench for aes_decipher_block_param: three instances (L=1, L=4, L=2 without AES-256)
// driven with FIPS-197 vectors; round keys come from a key schedule computed here.
module tb_aes_decipher_block_param;

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;

  logic         clk;
  logic         reset_n;
  logic         abort;
  logic         keylen;
  logic [127:0] block;
  logic [2:0]   nxt;
  logic [2:0]   rdy;
  logic [2:0]   dn;
  logic [3:0]   rnd  [3];
  logic [127:0] nb   [3];
  logic [127:0] rkey [3];
  logic [127:0] rk   [0:15];

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    string        tag;
    logic [127:0] pt;
    int           lat;
  } exp_t;
  exp_t sbq[$];

  assign rkey[0] = rk[rnd[0]];
  assign rkey[1] = rk[rnd[1]];
  assign rkey[2] = rk[rnd[2]];

  aes_decipher_block_param #(.SBOX_LANES(1), .SUPPORT_256(1'b1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .next(nxt[0]), .abort(abort), .keylen(keylen),
    .round_key(rkey[0]), .block(block), .round(rnd[0]), .new_block(nb[0]),
    .ready(rdy[0]), .done(dn[0]));

  aes_decipher_block_param #(.SBOX_LANES(4), .SUPPORT_256(1'b1)) u_l4 (
    .clk(clk), .reset_n(reset_n), .next(nxt[1]), .abort(abort), .keylen(keylen),
    .round_key(rkey[1]), .block(block), .round(rnd[1]), .new_block(nb[1]),
    .ready(rdy[1]), .done(dn[1]));

  aes_decipher_block_param #(.SBOX_LANES(2), .SUPPORT_256(1'b0)) u_l2 (
    .clk(clk), .reset_n(reset_n), .next(nxt[2]), .abort(abort), .keylen(keylen),
    .round_key(rkey[2]), .block(block), .round(rnd[2]), .new_block(nb[2]),
    .ready(rdy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  // Forward S-box: brute-force multiplicative inverse, then the affine transform.
  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gm(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] sw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic load_key(input logic [255:0] key, input bit k256);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk, nr;
    nk = k256 ? 8 : 4;
    nr = k256 ? 14 : 10;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = sw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a block on instance idx and waits (bounded) for ready to return.
  task automatic run_block(input string tag, input int idx, input logic [127:0] ct,
                           input bit kl, input int nr, input int pulse_at);
    exp_t e;
    int   cyc;
    bit   seen;
    @(negedge clk);
    block    = ct;
    keylen   = kl;
    nxt[idx] = 1'b1;
    e.tag = tag;
    e.pt  = PT;
    e.lat = 1 + nr * (4 / (idx == 0 ? 1 : (idx == 1 ? 4 : 2)) + 1);
    sbq.push_back(e);
    @(negedge clk);
    nxt[idx] = 1'b0;
    check({tag, "/round_start"}, 128'(rnd[idx]), 128'(nr));
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      if (rdy[idx]) begin
        seen = 1'b1;
      end else begin
        cyc++;
        if (cyc == pulse_at) begin
          nxt[idx] = 1'b1;
          block    = ~ct;
          keylen   = ~kl;
        end else if (cyc == pulse_at + 1) begin
          nxt[idx] = 1'b0;
        end
        @(negedge clk);
      end
    end
    nxt[idx] = 1'b0;
    check({tag, "/completed"}, 128'(seen), 128'(1));
    e = sbq.pop_front();
    check({e.tag, "/latency"}, 128'(cyc), 128'(e.lat));
    check({e.tag, "/plaintext"}, nb[idx], e.pt);
    check({e.tag, "/done_pulse"}, 128'(dn[idx]), 128'(1));
    @(negedge clk);
    check({e.tag, "/done_drop"}, 128'(dn[idx]), 128'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    abort   = 1'b0;
    keylen  = 1'b0;
    block   = '0;
    nxt     = '0;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    repeat (2) @(negedge clk);
    check("reset/ready", 128'(rdy), 128'(3'b111));
    check("reset/done", 128'(dn), 128'(3'b000));
    check("reset/round", 128'(rnd[0]), 128'(0));
    check("reset/new_block", nb[0], 128'(0));
    reset_n = 1'b1;

    load_key({C1_KEY, 128'h0}, 1'b0);
    run_block("c1_l1", 0, C1_CT, 1'b0, 10, -5);
    run_block("c1_l4", 1, C1_CT, 1'b0, 10, -5);
    run_block("c1_l2_no256_kl1", 2, C1_CT, 1'b1, 10, -5);
    run_block("c1_l1_next_ignored", 0, C1_CT, 1'b0, 10, 20);

    // Abort after 15 cycles: the round index stays where the abort found it.
    @(negedge clk);
    block  = C1_CT;
    keylen = 1'b0;
    nxt[0] = 1'b1;
    @(negedge clk);
    nxt[0] = 1'b0;
    repeat (14) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort/ready", 128'(rdy[0]), 128'(1));
    check("abort/done", 128'(dn[0]), 128'(0));
    check("abort/round_kept", 128'(rnd[0]), 128'(8));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort/no_done", 128'(dn[0]), 128'(0));
    end
    run_block("c1_after_abort", 0, C1_CT, 1'b0, 10, -5);

    // Asynchronous reset in the middle of a block.
    @(negedge clk);
    block  = C1_CT;
    nxt[0] = 1'b1;
    @(negedge clk);
    nxt[0] = 1'b0;
    repeat (29) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset/ready", 128'(rdy[0]), 128'(1));
    check("midreset/done", 128'(dn[0]), 128'(0));
    check("midreset/round", 128'(rnd[0]), 128'(0));
    check("midreset/new_block", nb[0], 128'(0));
    @(negedge clk);
    reset_n = 1'b1;
    run_block("c1_after_reset", 0, C1_CT, 1'b0, 10, -5);

    load_key(C3_KEY, 1'b1);
    run_block("c3_l4", 1, C3_CT, 1'b1, 14, -5);
    run_block("c3_l1", 0, C3_CT, 1'b1, 14, -5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
